rd53_cmd_encoder: RTL and testbench
===================================

# rd53_cmd_encoder

DAQ-side serializer for the RD53A command/data stream. It accepts 16-bit command frames through a valid/ready handshake and shifts them out MSB-first at one bit per CMD_CLK (160 MHz) on CMD_DATA. The output drives the chip's CMD_P/CMD_N pair. The block generates the sync frames the chip's channel-synchronizer needs: an initial lock burst, periodic re-sync, and idle fill.

## Interface

- SYNC_INIT, default 32: number of sync frames sent after reset before user frames are accepted. 0 means none.
- SYNC_PERIOD, default 32: a sync frame is forced after this many consecutive non-sync frames. 0 disables periodic sync.
- CMD_CLK  in  1  serial bit clock; all logic is on the rising edge.
- RESET_B  in  1  asynchronous active-low reset.
- FRAME_DATA  in  16  command frame; bit 15 is sent first.
- FRAME_VALID  in  1  FRAME_DATA is valid.
- FRAME_READY  out  1  the frame is accepted in this cycle if FRAME_VALID is high.
- CMD_DATA  out  1  serial command stream.
- FRAME_START  out  1  one-cycle pulse while bit 15 of any frame is on CMD_DATA.
- INIT_DONE  out  1  high once the initial sync burst is complete.

## Operation

- Datapath:
  - 16-bit shift register; CMD_DATA is its bit 15.
  - 4-bit bit counter.
  - A frame boundary is a cycle where the bit counter equals 15.
  - At each boundary the next frame is loaded and the counter goes to 0. Otherwise the register shifts left by one and the counter increments.
- States:
  - INIT: entered at reset.
    - Every boundary loads SYNC_FRAME and increments the init counter.
    - After SYNC_INIT sync frames have been loaded, the next boundary is handled as RUN and the state moves to RUN.
  - RUN: terminal until reset.
- Frame selection at a RUN boundary, in priority order:
  1. If the periodic counter equals SYNC_PERIOD and SYNC_PERIOD is not 0: load SYNC_FRAME.
  2. Else if FRAME_VALID is high: load FRAME_DATA and increment the periodic counter.
  3. Else: load the idle frame (see Configuration).
- Periodic counter rules:
  - Any loaded SYNC_FRAME clears it.
  - A loaded NOOP increments it.
  - It saturates at SYNC_PERIOD.
- FRAME_READY = RUN state AND boundary AND NOT sync-due. It is decoded from registers only; there is no combinational path from FRAME_VALID.
- When FRAME_VALID is high and FRAME_READY is low, the frame is held. Upstream must keep FRAME_DATA stable until it is accepted.
- Reset values:
  - CMD_DATA 0, FRAME_READY 0, FRAME_START 0, INIT_DONE 0.
  - Shift register 0, bit counter 15, both frame counters 0, state INIT.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately (asynchronous).
  - The partial frame is lost and not resent.
  - The init burst restarts after reset is released.

## Timing

- The first rising edge after RESET_B deasserts is a boundary. CMD_DATA shows bit 15 of the first sync frame after that edge.
- Frame accepted at edge k: bit 15 is on CMD_DATA after edge k and bit 0 after edge k+15. The next boundary is the cycle after edge k+15.
- Throughput is one frame per 16 cycles. Back-to-back frames have zero gap.
- INIT_DONE rises after the edge that loads the first RUN frame. With SYNC_INIT=0 it rises after the first edge, and that first edge already accepts a user frame.
- FRAME_START is high in the cycle after each load edge.

## Configuration

- RD53_CMD_IDLE_NOOP_EN:
  - Defined: the idle frame is NOOP_FRAME 16'h6969. Idle time therefore advances the periodic counter, and periodic sync still occurs during idle.
  - Undefined: the idle frame is SYNC_FRAME 16'h817E, which clears the periodic counter.

## Structure

- Package rd53_cmd_pkg:
  - SYNC_FRAME = 16'h817E (1000000101111110).
  - NOOP_FRAME = 16'h6969.
  - typedef cmd_frame_t (logic [15:0]).
  - Enum enc_state_t {INIT, RUN}.
- Sub-module rd53_cmd_ser holds the shift register, bit counter, boundary flag and FRAME_START. Frame selection, the counters and the state machine stay in the top level.

## Test plan

1. Reset release with FRAME_VALID low and SYNC_INIT=32 → CMD_DATA repeats 1000000101111110 for 32 frames (512 cycles). FRAME_READY stays low throughout. INIT_DONE rises at boundary 33.
2. After init, present 16'h5A5A → accepted at the next boundary. CMD_DATA is 0101101001011010 over the following 16 cycles, with FRAME_START on the first of them.
3. FRAME_VALID held high with 40 incrementing frames and SYNC_PERIOD=32 → frames 0–31 go out back-to-back, then one 16'h817E with FRAME_READY low at that boundary. Frame 32 is held and sent next with no loss or duplication.
4. Idle after init, run with and without RD53_CMD_IDLE_NOOP_EN → with the macro, 32 frames of 16'h6969 then one sync, repeating. Without it, continuous 16'h817E.
5. Reset asserted at bit 7 of user frame 16'hFFFF → CMD_DATA drops to 0 asynchronously. After release a full init burst follows and 16'hFFFF never appears.
6. SYNC_INIT=0, SYNC_PERIOD=0, FRAME_VALID held high → FRAME_READY high at the first boundary. No sync frame appears in 100 frames.

Source files
------------

// File: rtl/rd53_cmd_pkg.sv
// Shared types and constants for the RD53A command encoder.
package rd53_cmd_pkg;

    typedef logic [15:0] cmd_frame_t;

    localparam cmd_frame_t SYNC_FRAME = 16'h817E;
    localparam cmd_frame_t NOOP_FRAME = 16'h6969;

    // Width of the init-burst and periodic-sync frame counters.
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    // Increment that stops at the given limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        logic [CNT_W-1:0] result;
        if (value < limit) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/rd53_cmd_ser.sv
// Frame serializer: 16-bit shift register sent MSB-first, 4-bit bit counter,
// frame boundary decode and a one-cycle FRAME_START marker on bit 15.
module rd53_cmd_ser
    import rd53_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  cmd_frame_t load_frame,
    output logic       boundary,
    output logic       cmd_data,
    output logic       frame_start
);

    cmd_frame_t shift_r;
    logic [3:0] bit_cnt_r;
    logic       frame_start_r;

    // Load a new word on every boundary, otherwise shift left one bit per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r       <= 16'h0000;
            bit_cnt_r     <= 4'd15;
            frame_start_r <= 1'b0;
        end else if (bit_cnt_r == 4'd15) begin
            shift_r       <= load_frame;
            bit_cnt_r     <= 4'd0;
            frame_start_r <= 1'b1;
        end else begin
            shift_r       <= {shift_r[14:0], 1'b0};
            bit_cnt_r     <= bit_cnt_r + 4'd1;
            frame_start_r <= 1'b0;
        end
    end

    // Bit 0 of the current frame is on the line while the counter is 15,
    // so that same cycle is where the next word gets chosen.
    assign boundary    = (bit_cnt_r == 4'd15);
    assign cmd_data    = shift_r[15];
    assign frame_start = frame_start_r;

endmodule

// File: rtl/rd53_cmd_encoder.sv
// RD53A command stream encoder: accepts 16-bit frames over valid/ready and
// serializes them, inserting an initial sync burst, periodic re-sync and idle
// fill. Build option RD53_CMD_IDLE_NOOP_EN selects NOOP instead of SYNC as the
// idle frame.
module rd53_cmd_encoder
    import rd53_cmd_pkg::*;
#(
    parameter int unsigned SYNC_INIT   = 32,
    parameter int unsigned SYNC_PERIOD = 32
) (
    input  logic        CMD_CLK,
    input  logic        RESET_B,
    input  logic [15:0] FRAME_DATA,
    input  logic        FRAME_VALID,
    output logic        FRAME_READY,
    output logic        CMD_DATA,
    output logic        FRAME_START,
    output logic        INIT_DONE
);

    localparam logic [CNT_W-1:0] INIT_LIMIT   = CNT_W'(SYNC_INIT);
    localparam logic [CNT_W-1:0] PERIOD_LIMIT = CNT_W'(SYNC_PERIOD);
    localparam logic             PERIOD_EN    = (SYNC_PERIOD != 32'd0);

`ifdef RD53_CMD_IDLE_NOOP_EN
    localparam cmd_frame_t IDLE_FRAME = NOOP_FRAME;
`else
    localparam cmd_frame_t IDLE_FRAME = SYNC_FRAME;
`endif

    enc_state_t       state_r;
    logic [CNT_W-1:0] init_cnt_r;
    logic [CNT_W-1:0] per_cnt_r;
    logic             init_done_r;

    logic             boundary_s;
    logic             run_s;
    logic             sync_due_s;
    cmd_frame_t       load_frame_s;
    logic             load_sync_s;

    // The boundary that follows the last init sync is already a RUN boundary,
    // which lets SYNC_INIT=0 accept a user frame on the very first edge.
    assign run_s       = (state_r == RUN) || (init_cnt_r == INIT_LIMIT);
    assign sync_due_s  = PERIOD_EN && (per_cnt_r == PERIOD_LIMIT);
    // Decoded from state only; FRAME_VALID never feeds FRAME_READY.
    assign FRAME_READY = run_s && boundary_s && !sync_due_s;
    assign INIT_DONE   = init_done_r;

    // Choose the word loaded at the next boundary and flag whether it is a sync.
    always_comb begin
        load_frame_s = SYNC_FRAME;
        load_sync_s  = 1'b1;
        if (!run_s) begin
            load_frame_s = SYNC_FRAME;
            load_sync_s  = 1'b1;
        end else if (sync_due_s) begin
            load_frame_s = SYNC_FRAME;
            load_sync_s  = 1'b1;
        end else if (FRAME_VALID) begin
            load_frame_s = FRAME_DATA;
            load_sync_s  = 1'b0;
        end else begin
            load_frame_s = IDLE_FRAME;
            load_sync_s  = (IDLE_FRAME == SYNC_FRAME);
        end
    end

    // Advance the init burst, periodic-sync counter and state at each boundary.
    always_ff @(posedge CMD_CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_r     <= INIT;
            init_cnt_r  <= CNT_ZERO;
            per_cnt_r   <= CNT_ZERO;
            init_done_r <= 1'b0;
        end else if (boundary_s) begin
            if (load_sync_s) begin
                per_cnt_r <= CNT_ZERO;
            end else begin
                per_cnt_r <= sat_inc(per_cnt_r, PERIOD_LIMIT);
            end
            case (state_r)
                INIT: begin
                    if (run_s) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        init_cnt_r <= init_cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

    rd53_cmd_ser u_ser (
        .clk         (CMD_CLK),
        .rst_n       (RESET_B),
        .load_frame  (load_frame_s),
        .boundary    (boundary_s),
        .cmd_data    (CMD_DATA),
        .frame_start (FRAME_START)
    );

endmodule

// File: tb/tb_rd53_cmd_encoder.sv
// Self-checking bench for rd53_cmd_encoder: a default-parameter instance for
// init burst, back-to-back frames, periodic sync, idle fill and mid-frame
// reset, plus a SYNC_INIT=0/SYNC_PERIOD=0 instance for the no-sync case.
module tb_rd53_cmd_encoder;

    typedef struct {
        logic [15:0] word;
        logic        acc;
        int          cyc;
    } frame_t;

    localparam logic [15:0] SYNC_W = 16'h817E;
`ifdef RD53_CMD_IDLE_NOOP_EN
    localparam logic [15:0] IDLE_W = 16'h6969;
`else
    localparam logic [15:0] IDLE_W = 16'h817E;
`endif

    logic clk = 1'b0;
    always #3 clk = ~clk;

    logic        rst_n, rst2_n;
    logic [15:0] data, data2;
    logic        valid, valid2;
    logic        ready, cmd, fs, done;
    logic        ready2, cmd2, fs2, done2;

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t got_q[$];
    frame_t exp_q[$];
    int     cyc;
    int     init_done_cyc;

    rd53_cmd_encoder #(.SYNC_INIT(32), .SYNC_PERIOD(32)) dut (
        .CMD_CLK(clk), .RESET_B(rst_n), .FRAME_DATA(data), .FRAME_VALID(valid),
        .FRAME_READY(ready), .CMD_DATA(cmd), .FRAME_START(fs), .INIT_DONE(done)
    );

    rd53_cmd_encoder #(.SYNC_INIT(0), .SYNC_PERIOD(0)) dut2 (
        .CMD_CLK(clk), .RESET_B(rst2_n), .FRAME_DATA(data2), .FRAME_VALID(valid2),
        .FRAME_READY(ready2), .CMD_DATA(cmd2), .FRAME_START(fs2), .INIT_DONE(done2)
    );

    // Frame collector for the main instance: rebuilds each serialized word from
    // FRAME_START onward, tagging whether a user frame was accepted at the
    // boundary that loaded it and the cycle (since reset release) it started.
    initial begin : monitor
        logic [15:0] bits;
        int          nb;
        int          start_cyc;
        logic        prev_acc;
        logic        cur_acc;
        bits = 16'h0000; nb = 0; start_cyc = 0; prev_acc = 1'b0; cur_acc = 1'b0;
        cyc = 0; init_done_cyc = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got_q.delete();
                nb = 0; cyc = 0; init_done_cyc = -1; prev_acc = 1'b0;
            end else begin
                cyc++;
                if (done && init_done_cyc < 0) init_done_cyc = cyc;
                if (fs) begin
                    bits = {15'd0, cmd}; nb = 1; start_cyc = cyc; cur_acc = prev_acc;
                end else if (nb > 0) begin
                    bits = {bits[14:0], cmd}; nb++;
                end
                if (nb == 16) begin
                    got_q.push_back('{bits, cur_acc, start_cyc});
                    nb = 0;
                end
                prev_acc = ready && valid;
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic add_exp(input logic [15:0] w, input logic a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{w, a, 1 + 16 * exp_q.size()});
    endtask

    task automatic wait_ready(input int limit, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic compare_frames(input string name);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() < exp_q.size()) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got %0d frames expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].word !== exp_q[i].word || got_q[i].acc !== exp_q[i].acc ||
                got_q[i].cyc != exp_q[i].cyc) begin
                n_errors++;
                $display("FAIL %s[%0d]: got word %h acc %b cycle %0d expected word %h acc %b cycle %0d",
                         name, i, got_q[i].word, got_q[i].acc, got_q[i].cyc,
                         exp_q[i].word, exp_q[i].acc, exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        logic        ok;
        logic [15:0] exp2;
        logic [15:0] got2;
        logic        fs_ok;

        rst_n = 1'b0; rst2_n = 1'b0;
        valid = 1'b1; data = 16'h5A5A;
        valid2 = 1'b0; data2 = 16'h0100;
        repeat (3) @(negedge clk);
        #1;
        check_bit("reset_cmd_data", cmd, 1'b0);
        check_bit("reset_frame_ready", ready, 1'b0);
        check_bit("reset_frame_start", fs, 1'b0);
        check_bit("reset_init_done", done, 1'b0);
        rst_n = 1'b1;

        // Init burst, 32 back-to-back frames, forced sync, held frame 32, idle fill.
        for (int i = 0; i < 40; i++) begin
            data  = 16'h5A5A + 16'(i);
            valid = 1'b1;
            wait_ready(600, ok);
            check_bit($sformatf("ready_frame%0d", i), ok, 1'b1);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;

        exp_q.delete();
        add_exp(SYNC_W, 1'b0, 32);
        for (int i = 0; i < 32; i++) add_exp(16'h5A5A + 16'(i), 1'b1, 1);
        add_exp(SYNC_W, 1'b0, 1);
        for (int i = 32; i < 40; i++) add_exp(16'h5A5A + 16'(i), 1'b1, 1);
        add_exp(IDLE_W, 1'b0, 3);
        compare_frames("run");
        check_int("init_done_cycle", init_done_cyc, 513);

        // Reset in the middle of a 16'hFFFF frame.
        data = 16'hFFFF; valid = 1'b1;
        wait_ready(40, ok);
        check_bit("ffff_ready", ok, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_bit("ffff_bit15", cmd, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_bit("ffff_bit7", cmd, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("async_cmd_data", cmd, 1'b0);
        check_bit("async_frame_ready", ready, 1'b0);
        check_bit("async_frame_start", fs, 1'b0);
        check_bit("async_init_done", done, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        add_exp(SYNC_W, 1'b0, 32);
        add_exp(IDLE_W, 1'b0, 2);
        compare_frames("reinit");
        check_int("reinit_done_cycle", init_done_cyc, 513);

        // SYNC_INIT=0, SYNC_PERIOD=0: user frames from the first edge, never a sync.
        valid2 = 1'b1; data2 = 16'h0100;
        @(negedge clk);
        #1;
        rst2_n = 1'b1;
        #1;
        check_bit("nosync_first_ready", ready2, 1'b1);
        for (int k = 0; k < 100; k++) begin
            exp2 = 16'h0100 + 16'(k);
            got2 = 16'h0000;
            fs_ok = 1'b0;
            @(posedge clk);
            #1;
            data2 = exp2 + 16'h0001;
            for (int b = 15; b >= 0; b--) begin
                @(negedge clk);
                got2[b] = cmd2;
                if (b == 15) fs_ok = fs2;
            end
            n_checks++;
            if (got2 !== exp2 || fs_ok !== 1'b1 || ready2 !== 1'b1) begin
                n_errors++;
                $display("FAIL nosync_frame%0d: got word %h start %b ready %b expected word %h start 1 ready 1",
                         k, got2, fs_ok, ready2, exp2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
